// File: rtl/appliance_pkg.sv
// Shared definitions for the appliance sequencer: detector event codes,
// FSM state encoding and the default seconds-counter width.
package appliance_pkg;

  localparam logic [2:0] CODE_BUZZ = 3'b000;
  localparam logic [2:0] CODE_ERR  = 3'b001;
  localparam logic [2:0] CODE_ON   = 3'b010;
  localparam logic [2:0] CODE_OFF  = 3'b011;
  localparam logic [2:0] CODE_OPEN = 3'b100;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ALARM = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/appliance_seq_ctrl_if.sv
// Detector-code input and appliance drive/status bundle between the
// sequencer (slave) and whoever drives the detector code (master).
interface appliance_seq_ctrl_if
  import appliance_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [2:0]       state_code;
  logic             heater_en;
  logic             buzzer;
  logic             err_led;
  logic             door_led;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       fsm_state;

  modport master (
    output state_code,
    input  heater_en, buzzer, err_led, door_led, done, remaining, fsm_state
  );

  modport slave (
    input  state_code,
    output heater_en, buzzer, err_led, door_led, done, remaining, fsm_state
  );
endinterface

// File: rtl/appliance_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICK_DIV cycles
// while run is high; run low holds the count at zero.
module appliance_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = run && (cnt_r == LAST);

  // prescaler count, restarted whenever counting is suspended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (!run) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end
endmodule

// File: rtl/appliance_seq_ctrl.sv
// Appliance cook/run sequencer: event decode, FSM, seconds counters and registered outputs.
// Build macro APPLIANCE_PAUSE_TIMEOUT_EN adds an automatic return to IDLE after PAUSE_SECS paused.
module appliance_seq_ctrl
  import appliance_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int RUN_SECS   = 60,
  parameter int BUZZ_SECS  = 3,
  parameter int PAUSE_SECS = 30,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  appliance_seq_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(RUN_SECS);
  localparam logic [CNT_W-1:0] BUZZ_LOAD = CNT_W'(BUZZ_SECS);

  logic [2:0]       code_s;
  logic [2:0]       prev_code_r;
  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] rem_r, rem_nxt_s;
  logic [CNT_W-1:0] alarm_r, alarm_nxt_s;
  logic             heater_en_r, buzzer_r, err_led_r, door_led_r, done_r;
  logic             door_nxt_s, done_nxt_s;
  logic             ev_valid_s, ev_act_s, count_st_s, run_s, tick_s;

`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_SECS);
  logic [CNT_W-1:0] pause_r, pause_nxt_s;
`else
  logic [31:0] unused_pause_cfg_s;
  assign unused_pause_cfg_s = 32'(PAUSE_SECS);
`endif

  assign code_s     = bus.state_code;
  assign ev_valid_s = (code_s != prev_code_r) && (code_s <= CODE_OPEN);

  // events that move the FSM; kept free of tick so the prescaler restart has no loop
  always_comb begin
    ev_act_s = 1'b0;
    if (!ev_valid_s) begin
      ev_act_s = 1'b0;
    end else if (code_s == CODE_ERR) begin
      ev_act_s = (state_r != ST_FAULT);
    end else begin
      case (state_r)
        ST_IDLE:  ev_act_s = (code_s == CODE_ON) || (code_s == CODE_BUZZ);
        ST_RUN:   ev_act_s = (code_s == CODE_OFF) || (code_s == CODE_OPEN);
        ST_PAUSE: ev_act_s = (code_s == CODE_ON) || (code_s == CODE_OFF) || (code_s == CODE_BUZZ);
        ST_ALARM: ev_act_s = (code_s == CODE_OFF) || (code_s == CODE_ON);
        ST_FAULT: ev_act_s = (code_s == CODE_OFF);
        default:  ev_act_s = 1'b0;
      endcase
    end
  end

  // states in which whole seconds are being counted
  always_comb begin
    count_st_s = 1'b0;
    case (state_r)
      ST_RUN, ST_ALARM: count_st_s = 1'b1;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
      ST_PAUSE:         count_st_s = 1'b1;
`endif
      default:          count_st_s = 1'b0;
    endcase
  end

  assign run_s = count_st_s && !ev_act_s;

  appliance_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .tick  (tick_s)
  );

  // next-state and counter update; tick is already suppressed by any acting event
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    alarm_nxt_s = ZERO;
    door_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
    pause_nxt_s = ZERO;
`endif
    if (ev_valid_s && (code_s == CODE_ERR)) begin
      state_nxt_s = ST_FAULT;
      rem_nxt_s   = ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ev_valid_s && (code_s == CODE_ON)) begin
            state_nxt_s = ST_RUN;
            rem_nxt_s   = RUN_LOAD;
          end else if (ev_valid_s && (code_s == CODE_BUZZ)) begin
            state_nxt_s = ST_ALARM;
            alarm_nxt_s = BUZZ_LOAD;
          end else if (ev_valid_s && (code_s == CODE_OPEN)) begin
            door_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ev_valid_s && (code_s == CODE_OFF)) begin
            state_nxt_s = ST_IDLE;
            rem_nxt_s   = ZERO;
          end else if (ev_valid_s && (code_s == CODE_OPEN)) begin
            state_nxt_s = ST_PAUSE;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
            pause_nxt_s = PAUSE_LOAD;
`endif
          end else if (tick_s && (rem_r > ONE)) begin
            rem_nxt_s   = rem_r - ONE;
          end else if (tick_s) begin
            state_nxt_s = ST_ALARM;
            rem_nxt_s   = ZERO;
            done_nxt_s  = 1'b1;
            alarm_nxt_s = BUZZ_LOAD;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (ev_valid_s && (code_s == CODE_ON)) begin
            state_nxt_s = ST_RUN;
          end else if (ev_valid_s && (code_s == CODE_OFF)) begin
            state_nxt_s = ST_IDLE;
            rem_nxt_s   = ZERO;
          end else if (ev_valid_s && (code_s == CODE_BUZZ)) begin
            state_nxt_s = ST_ALARM;
            rem_nxt_s   = ZERO;
            alarm_nxt_s = BUZZ_LOAD;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
          end else if (tick_s && (pause_r <= ONE)) begin
            state_nxt_s = ST_IDLE;
            rem_nxt_s   = ZERO;
          end else if (tick_s) begin
            pause_nxt_s = pause_r - ONE;
          end else begin
            pause_nxt_s = pause_r;
`else
          end else begin
            state_nxt_s = ST_PAUSE;
`endif
          end
        end
        ST_ALARM: begin
          if (ev_valid_s && (code_s == CODE_OFF)) begin
            state_nxt_s = ST_IDLE;
          end else if (ev_valid_s && (code_s == CODE_ON)) begin
            state_nxt_s = ST_RUN;
            rem_nxt_s   = RUN_LOAD;
          end else if (tick_s && (alarm_r <= ONE)) begin
            state_nxt_s = ST_IDLE;
          end else if (tick_s) begin
            alarm_nxt_s = alarm_r - ONE;
          end else begin
            alarm_nxt_s = alarm_r;
          end
        end
        ST_FAULT: begin
          if (ev_valid_s && (code_s == CODE_OFF)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          rem_nxt_s   = ZERO;
        end
      endcase
    end
  end

  // state, counters and outputs all registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code_r <= CODE_OFF;
      state_r     <= ST_IDLE;
      rem_r       <= ZERO;
      alarm_r     <= ZERO;
      heater_en_r <= 1'b0;
      buzzer_r    <= 1'b0;
      err_led_r   <= 1'b0;
      door_led_r  <= 1'b0;
      done_r      <= 1'b0;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
      pause_r     <= ZERO;
`endif
    end else begin
      prev_code_r <= code_s;
      state_r     <= state_nxt_s;
      rem_r       <= rem_nxt_s;
      alarm_r     <= alarm_nxt_s;
      heater_en_r <= (state_nxt_s == ST_RUN);
      buzzer_r    <= (state_nxt_s == ST_ALARM);
      err_led_r   <= (state_nxt_s == ST_FAULT);
      door_led_r  <= (state_nxt_s == ST_PAUSE) || door_nxt_s;
      done_r      <= done_nxt_s;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
      pause_r     <= pause_nxt_s;
`endif
    end
  end

  assign bus.heater_en = heater_en_r;
  assign bus.buzzer    = buzzer_r;
  assign bus.err_led   = err_led_r;
  assign bus.door_led  = door_led_r;
  assign bus.done      = done_r;
  assign bus.remaining = rem_r;
  assign bus.fsm_state = state_r;
endmodule

// File: tb/tb_appliance_seq_ctrl.sv
// Self-checking bench for appliance_seq_ctrl: directed scenarios plus random
// detector-code sequences, all compared against a behavioural model.
module tb_appliance_seq_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int RUN_SECS   = 3;
  localparam int BUZZ_SECS  = 2;
  localparam int PAUSE_SECS = 2;
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
  localparam bit PTO = 1'b1;
`else
  localparam bit PTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  appliance_seq_ctrl_if #(.CNT_W(8)) bus ();

  appliance_seq_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .RUN_SECS   (RUN_SECS),
    .BUZZ_SECS  (BUZZ_SECS),
    .PAUSE_SECS (PAUSE_SECS),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 run, 2 pause, 3 alarm, 4 fault; age = cycles into current second
  int         m_mode, m_secs, m_alarm, m_pause, m_age;
  bit         m_done, m_door_pulse;
  logic [2:0] m_prev;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_alarm = 0; m_pause = 0; m_age = 0;
    m_done = 1'b0; m_door_pulse = 1'b0; m_prev = 3'b011;
  endtask

  task automatic model_step(input logic [2:0] code);
    bit ev;
    bit timing;
    int nm;
    ev = (code != m_prev) && (code <= 3'd4);
    m_prev = code;
    nm = m_mode;
    m_done = 1'b0;
    m_door_pulse = 1'b0;
    if (ev && code == 3'd1) begin
      nm = 4; m_secs = 0;
    end else if (ev) begin
      case (m_mode)
        0: if (code == 3'd2) begin nm = 1; m_secs = RUN_SECS; end
           else if (code == 3'd0) begin nm = 3; m_alarm = BUZZ_SECS; end
           else if (code == 3'd4) m_door_pulse = 1'b1;
        1: if (code == 3'd3) begin nm = 0; m_secs = 0; end
           else if (code == 3'd4) begin nm = 2; m_pause = PAUSE_SECS; end
        2: if (code == 3'd2) nm = 1;
           else if (code == 3'd3) begin nm = 0; m_secs = 0; end
           else if (code == 3'd0) begin nm = 3; m_secs = 0; m_alarm = BUZZ_SECS; end
        3: if (code == 3'd3) nm = 0;
           else if (code == 3'd2) begin nm = 1; m_secs = RUN_SECS; end
        4: if (code == 3'd3) nm = 0;
        default: nm = 0;
      endcase
    end
    timing = (m_mode == 1) || (m_mode == 3) || (PTO && m_mode == 2);
    if (nm != m_mode || !timing) begin
      m_age = 0;
    end else if (m_age < TICK_DIV - 1) begin
      m_age++;
    end else begin
      m_age = 0;
      if (m_mode == 1) begin
        if (m_secs > 1) m_secs--;
        else begin nm = 3; m_secs = 0; m_done = 1'b1; m_alarm = BUZZ_SECS; end
      end else if (m_mode == 3) begin
        if (m_alarm > 1) m_alarm--;
        else nm = 0;
      end else begin
        if (m_pause > 1) m_pause--;
        else begin nm = 0; m_secs = 0; end
      end
    end
    m_mode = nm;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".fsm_state"}, 32'(bus.fsm_state), 32'(m_mode));
    check({tag, ".heater_en"}, 32'(bus.heater_en), 32'(m_mode == 1));
    check({tag, ".buzzer"},    32'(bus.buzzer),    32'(m_mode == 3));
    check({tag, ".err_led"},   32'(bus.err_led),   32'(m_mode == 4));
    check({tag, ".door_led"},  32'(bus.door_led),  32'((m_mode == 2) || m_door_pulse));
    check({tag, ".done"},      32'(bus.done),      32'(m_done));
    check({tag, ".remaining"}, 32'(bus.remaining), 32'(m_secs));
  endtask

  task automatic step(input logic [2:0] code, input string tag);
    @(negedge clk);
    bus.state_code = code;
    model_step(code);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.state_code = 3'b011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int r;
    int len;
    logic [2:0] code;
    model_reset();
    do_reset();
    check_outputs("reset");
    check("reset_fsm", 32'(bus.fsm_state), 32'd0);
    step(3'b011, "off_idle");
    step(3'b011, "off_idle2");

    // countdown to alarm and back to idle
    step(3'b010, "run_entry");
    check("run_entry_rem", 32'(bus.remaining), 32'd3);
    check("run_entry_heat", 32'(bus.heater_en), 32'd1);
    for (int i = 1; i <= 12; i++) step(3'b010, "countdown");
    check("alarm_entry_fsm", 32'(bus.fsm_state), 32'd3);
    check("alarm_entry_done", 32'(bus.done), 32'd1);
    for (int i = 1; i <= 8; i++) step(3'b010, "alarm");
    check("alarm_exit_fsm", 32'(bus.fsm_state), 32'd0);

    // pause at cycle 5 of a run, then resume
    step(3'b011, "rearm");
    step(3'b010, "run2_entry");
    for (int i = 1; i <= 4; i++) step(3'b010, "run2");
    step(3'b100, "pause_entry");
    check("pause_rem", 32'(bus.remaining), 32'd2);
    check("pause_door", 32'(bus.door_led), 32'd1);
    for (int i = 0; i < 3; i++) step(3'b100, "paused");
    step(3'b010, "resume");
    check("resume_rem", 32'(bus.remaining), 32'd2);
    for (int i = 1; i <= 8; i++) step(3'b010, "resumed");
    check("resume_alarm", 32'(bus.fsm_state), 32'd3);
    step(3'b011, "silence");

    // fault lockout
    step(3'b010, "run3_entry");
    step(3'b010, "run3");
    step(3'b001, "fault_entry");
    check("fault_err", 32'(bus.err_led), 32'd1);
    step(3'b010, "fault_on");
    step(3'b000, "fault_buzz");
    check("fault_hold", 32'(bus.fsm_state), 32'd4);
    step(3'b011, "fault_off");
    check("fault_exit", 32'(bus.fsm_state), 32'd0);

    // asynchronous reset in the middle of a run
    step(3'b010, "run4_entry");
    for (int i = 0; i < 5; i++) step(3'b010, "run4");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_fsm", 32'(bus.fsm_state), 32'd0);
    check("async_rst_heat", 32'(bus.heater_en), 32'd0);
    check("async_rst_rem", 32'(bus.remaining), 32'd0);
    do_reset();
    check_outputs("post_reset");
    step(3'b010, "run5_entry");
    check("run5_rem", 32'(bus.remaining), 32'd3);

    // pause held for a long time
    step(3'b100, "pause2_entry");
    for (int i = 0; i < 100; i++) step(3'b100, "pause2");
`ifdef APPLIANCE_PAUSE_TIMEOUT_EN
    check("pause_timeout_fsm", 32'(bus.fsm_state), 32'd0);
`else
    check("pause_hold_fsm", 32'(bus.fsm_state), 32'd2);
`endif

    // random detector-code sequences, biased toward ON and OPEN
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 11);
      if (r < 8) code = 3'(r);
      else if (r < 10) code = 3'b010;
      else code = 3'b100;
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) step(code, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/appliance_seq_ctrl.md
Name: appliance_seq_ctrl

Overview:
Sequencing controller for the board's appliance event path. It consumes the 3-bit event code from the front-panel state detector and runs a timed cook/run cycle. The cycle includes door-open pause, fault lockout and a timed buzzer alarm. It drives the heater enable, buzzer and status LEDs, and exposes the remaining seconds for the display.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s tick (≥2)
RUN_SECS, 60, seconds loaded on start (1..2^CNT_W-1)
BUZZ_SECS, 3, alarm duration in seconds (≥1)
PAUSE_SECS, 30, pause timeout in seconds; used only with the optional feature
CNT_W, 8, width of the seconds counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state_code  in  3  detector code, synchronous to clk: 000 BUZZ, 001 ERR, 010 ON, 011 OFF, 100 OPEN; 101–111 ignored
heater_en  out  1  heater/motor drive, high only in RUN
buzzer  out  1  high only in ALARM
err_led  out  1  high only in FAULT
door_led  out  1  high in PAUSE, and for one cycle after an OPEN event in IDLE
done  out  1  one-cycle pulse when a run completes by countdown
remaining  out  CNT_W  seconds left in current or paused run, 0 otherwise
fsm_state  out  3  IDLE 0, RUN 1, PAUSE 2, ALARM 3, FAULT 4

Behaviour:
- Reset (async assert, sync release):
  - fsm_state=IDLE; all outputs 0.
  - prev_code=011 (OFF); prescaler=0; alarm counter=0.
- Event detection: an event exists in a cycle when state_code != prev_code and the code is 000–100. prev_code is updated every cycle. Codes 101–111 update prev_code but produce no event. Only one event can exist per cycle.
- Latency: FSM state and all outputs are registered. They change on the first clk edge after state_code changes (1 cycle).
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and ALARM; tick is asserted when it reaches TICK_DIV-1, then it wraps to 0.
  - Forced to 0 in every other state and on every state change, so the first second after entry is always full. A partial second is discarded on pause.
- Transitions (ERR has priority over everything):
  - Any state, ERR event → FAULT; heater_en is cleared in the same edge; remaining is cleared.
  - FAULT: only an OFF event → IDLE. All other events are ignored.
  - IDLE:
    - ON → RUN, remaining=RUN_SECS.
    - BUZZ → ALARM.
    - OPEN → stays IDLE; door_led pulses for 1 cycle.
    - OFF is ignored.
  - RUN:
    - On tick, remaining decrements.
    - Tick with remaining==1 → ALARM, remaining=0, done=1 for that one cycle.
    - OFF → IDLE, remaining=0.
    - OPEN → PAUSE, remaining held.
    - BUZZ and ON are ignored.
    - An event and a tick in the same cycle: the event wins and no decrement occurs.
  - PAUSE:
    - ON → RUN, resuming the held remaining.
    - OFF → IDLE, remaining=0.
    - BUZZ → ALARM, remaining=0.
    - OPEN cannot re-occur without an intervening change.
  - ALARM:
    - Alarm counter loads BUZZ_SECS on entry and decrements per tick.
    - Tick with counter==1 → IDLE.
    - OFF event → IDLE immediately (silence).
    - ON → RUN with RUN_SECS (restart).
- Counters never underflow; remaining saturates at 0.

Optional Feature:
APPLIANCE_PAUSE_TIMEOUT_EN:
- Defined:
  - The prescaler also runs in PAUSE.
  - A pause counter loads PAUSE_SECS on PAUSE entry and decrements per tick.
  - Tick with counter==1 → IDLE, remaining=0, no done pulse.
  - Any exit from PAUSE clears the pause counter.
- Undefined: PAUSE is held indefinitely; no pause counter logic is synthesized.

Decomposition:
- Package appliance_pkg holds:
  - event-code localparams (CODE_BUZZ..CODE_OPEN);
  - the FSM state encoding (ST_IDLE..ST_FAULT, 3 bits);
  - the shared default for CNT_W.
- Sub-module appliance_tick_gen (param TICK_DIV; ports clk, rst_n, run, tick) implements the prescaler. run=0 holds the count at 0.
- The FSM, the seconds counters and output decode stay in the top module.

Test Plan:
Bench parameters: TICK_DIV=4, RUN_SECS=3, BUZZ_SECS=2, PAUSE_SECS=2.
1. Reset → all outputs 0, fsm_state=0. Drive code 011 → no event, stays IDLE.
2. Countdown and alarm:
   - Stimulus: code 010.
   - Next edge: fsm_state=1, heater_en=1, remaining=3.
   - remaining steps 3→2→1 every 4 cycles.
   - 12 cycles after entry: fsm_state=3, done=1 for one cycle, buzzer=1 for 8 cycles, then IDLE.
3. Pause and resume:
   - Stimulus: RUN, then code 100 at cycle 5 after entry.
   - Response: PAUSE, heater_en=0, door_led=1, remaining=2.
   - Then code 010 → RUN resumes at 2; ALARM follows 8 cycles later.
4. Fault lockout:
   - Stimulus: code 001 in RUN.
   - Response: FAULT, err_led=1, heater_en=0, remaining=0.
   - Codes 010/000 are ignored; code 011 → IDLE.
5. Reset mid-run: rst_n low mid-RUN → all outputs 0 asynchronously, before the next clk edge. After release, code 010 → a normal run starts.
6. Pause timeout:
   - With APPLIANCE_PAUSE_TIMEOUT_EN defined: PAUSE held 8 cycles → IDLE, remaining=0, done=0.
   - Without the macro: still PAUSE after 100 cycles.
